// File: rtl/fxp_div_if.sv
// Handshake bundle for the sequential fixed-point divider.
// master drives operands and accepts results; slave is the divider.
interface fxp_div_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, div_by_zero, overflow
  );
endinterface

// File: rtl/fxp_div_seq.sv
// Sequential signed fixed-point divider: Q = (A << FRAC) / B,
// radix-2 restoring on magnitudes, saturating, one bit per clock.
module fxp_div_seq #(
  parameter int WIDTH = 64,
  parameter int FRAC  = 32
) (
  input logic      clk,
  input logic      rst,
  fxp_div_if.slave bus
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  localparam logic [WIDTH-1:0] MAXQ = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINQ = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [N-1:0]     num;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] babs;
  logic [CW-1:0]    cnt;
  logic             sign;
  logic             zflag;
  logic             aneg;

  logic [WIDTH-1:0] aabs_c;
  logic [WIDTH-1:0] babs_c;
  logic [N-1:0]     num_load;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_c;
  logic             ov_c;

  // |min| wraps to 2^(W-1), which is correct as an unsigned magnitude
  assign aabs_c = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign babs_c = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign num_load = N'(aabs_c) << FRAC;

  // num doubles as the quotient: its LSB receives each new quotient bit
  assign rem_sh = {rem, num[N-1]};
  assign ge     = rem_sh >= {1'b0, babs};
  assign rem_nx = ge ? WIDTH'(rem_sh - {1'b0, babs})
                     : rem_sh[WIDTH-1:0];

  always_comb begin
    q_c  = num[WIDTH-1:0];
    ov_c = 1'b0;
    if (zflag) begin
      q_c = aneg ? MINQ : MAXQ;
    end else if (!sign) begin
      if (num > N'(MAXQ)) begin
        q_c  = MAXQ;
        ov_c = 1'b1;
      end
    end else if (num > N'(MINQ)) begin
      q_c  = MINQ;
      ov_c = 1'b1;
    end else begin
      q_c = -num[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
      num             <= '0;
      rem             <= '0;
      babs            <= '0;
      cnt             <= '0;
      sign            <= 1'b0;
      zflag           <= 1'b0;
      aneg            <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign            <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            aneg            <= bus.dividend[WIDTH-1];
            zflag           <= (bus.divisor == '0);
            babs            <= babs_c;
            num             <= num_load;
            rem             <= '0;
            cnt             <= CW'(N);
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.in_ready    <= 1'b0;
            state           <= CALC;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            rem <= rem_nx;
            num <= {num[N-2:0], ge};
            cnt <= cnt - 1'b1;
          end else begin
            bus.quotient    <= q_c;
            bus.div_by_zero <= zflag;
            bus.overflow    <= ov_c;
            bus.out_valid   <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
